// File: rtl/debounce_pkg.sv
// Shared types, width helper and default counter widths for debounce_arbiter.
package debounce_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_COUNT = 1'b1
   } state_e;

   localparam int unsigned CNT_W_HW  = 20;
   localparam int unsigned CNT_W_SIM = 4;

   // ceil(log2(n)) with a floor of 1 so a single button still has a 1-bit index
   function automatic int unsigned idx_width(input int unsigned n);
      int unsigned w;
      w = 1;
      while ((1 << w) < n) w++;
      return w;
   endfunction

endpackage

// File: rtl/debounce_arbiter_if.sv
// Button/press-event bundle for debounce_arbiter; abort_cnt exists only with DEB_ABORT_CNT_EN.
interface debounce_arbiter_if
   import debounce_pkg::*;
#(
   parameter int unsigned N_BTN = 4,
   parameter int unsigned IDX_W = idx_width(N_BTN)
);
   logic [N_BTN-1:0] btn_in;
   logic             press_valid;
   logic [IDX_W-1:0] press_id;
   logic             busy;
   logic [IDX_W-1:0] grant_id;
`ifdef DEB_ABORT_CNT_EN
   logic [7:0]       abort_cnt;
`endif

   modport master (
      output btn_in,
`ifdef DEB_ABORT_CNT_EN
      input  abort_cnt,
`endif
      input  press_valid, press_id, busy, grant_id
   );

   modport slave (
      input  btn_in,
`ifdef DEB_ABORT_CNT_EN
      output abort_cnt,
`endif
      output press_valid, press_id, busy, grant_id
   );
endinterface

// File: rtl/debounce_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request scanning from rr_ptr upward, modulo N_BTN.
module rr_picker
#(
   parameter int unsigned N_BTN = 4,
   parameter int unsigned IDX_W = 2
) (
   input  logic [N_BTN-1:0] req,
   input  logic [IDX_W-1:0] rr_ptr,
   output logic             any_req,
   output logic [IDX_W-1:0] pick_idx
);

   int unsigned idx;

   always_comb begin
      any_req  = |req;
      pick_idx = rr_ptr;
      idx      = 0;
      for (int unsigned off = N_BTN; off > 0; off--) begin
         // scan backwards so the last hit is the one closest to rr_ptr
         idx = (32'(rr_ptr) + off - 1) % N_BTN;
         if (req[IDX_W'(idx)]) pick_idx = IDX_W'(idx);
      end
   end

endmodule

// File: rtl/debounce_arbiter.sv
// N-button debouncer sharing one counter, granted round-robin to pending buttons.
// Optional DEB_ABORT_CNT_EN adds a saturating count of bounce aborts.
module debounce_arbiter
   import debounce_pkg::*;
#(
   parameter int unsigned N_BTN = 4,
   parameter int unsigned CNT_W = CNT_W_HW,
   parameter int unsigned IDX_W = idx_width(N_BTN)
) (
   input  logic             clk,
   input  logic             resetn,
   debounce_arbiter_if.slave bus
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   state_e           state_q,       state_d;
   logic [CNT_W-1:0] cnt_q,         cnt_d;
   logic [IDX_W-1:0] rr_ptr_q,      rr_ptr_d;
   logic [N_BTN-1:0] done_mask_q,   done_mask_d;
   logic [IDX_W-1:0] grant_id_q,    grant_id_d;
   logic             press_valid_q, press_valid_d;
   logic [IDX_W-1:0] press_id_q,    press_id_d;
   logic             busy_q,        busy_d;
`ifdef DEB_ABORT_CNT_EN
   logic [7:0]       abort_cnt_q,   abort_cnt_d;
`endif

   logic [N_BTN-1:0] req;
   logic             any_req;
   logic [IDX_W-1:0] pick_idx;

   assign req = bus.btn_in & ~done_mask_q;

   rr_picker #(.N_BTN(N_BTN), .IDX_W(IDX_W)) u_picker (
      .req      (req),
      .rr_ptr   (rr_ptr_q),
      .any_req  (any_req),
      .pick_idx (pick_idx)
   );

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q       <= ST_IDLE;
         cnt_q         <= '0;
         rr_ptr_q      <= '0;
         done_mask_q   <= '0;
         grant_id_q    <= '0;
         press_valid_q <= 1'b0;
         press_id_q    <= '0;
         busy_q        <= 1'b0;
`ifdef DEB_ABORT_CNT_EN
         abort_cnt_q   <= '0;
`endif
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         rr_ptr_q      <= rr_ptr_d;
         done_mask_q   <= done_mask_d;
         grant_id_q    <= grant_id_d;
         press_valid_q <= press_valid_d;
         press_id_q    <= press_id_d;
         busy_q        <= busy_d;
`ifdef DEB_ABORT_CNT_EN
         abort_cnt_q   <= abort_cnt_d;
`endif
      end
   end

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      rr_ptr_d      = rr_ptr_q;
      grant_id_d    = grant_id_q;
      press_valid_d = 1'b0;
      press_id_d    = press_id_q;
      // a released button re-arms on any edge it is seen low
      done_mask_d   = done_mask_q & bus.btn_in;
`ifdef DEB_ABORT_CNT_EN
      abort_cnt_d   = abort_cnt_q;
`endif

      case (state_q)
         ST_IDLE: begin
            if (any_req) begin
               grant_id_d = pick_idx;
               cnt_d      = '0;
               rr_ptr_d   = (pick_idx == IDX_W'(N_BTN - 1)) ? '0 : pick_idx + IDX_W'(1);
               state_d    = ST_COUNT;
            end
         end
         ST_COUNT: begin
            if (!bus.btn_in[grant_id_q]) begin
               cnt_d   = '0;
               state_d = ST_IDLE;
`ifdef DEB_ABORT_CNT_EN
               if (abort_cnt_q != 8'hFF) abort_cnt_d = abort_cnt_q + 8'd1;
`endif
            end else if (cnt_q == CNT_MAX) begin
               press_valid_d           = 1'b1;
               press_id_d              = grant_id_q;
               done_mask_d[grant_id_q] = 1'b1;
               cnt_d                   = '0;
               state_d                 = ST_IDLE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase

      busy_d = (state_d == ST_COUNT);
   end

   assign bus.press_valid = press_valid_q;
   assign bus.press_id    = press_id_q;
   assign bus.busy        = busy_q;
   assign bus.grant_id    = grant_id_q;
`ifdef DEB_ABORT_CNT_EN
   assign bus.abort_cnt   = abort_cnt_q;
`endif

endmodule

// File: tb/tb_debounce_arbiter.sv
// Directed self-checking bench for debounce_arbiter with CNT_W=4, N_BTN=4.
module tb_debounce_arbiter;
   import debounce_pkg::*;

   localparam int unsigned NB = 4;
   localparam int unsigned IW = 2;

   logic clk;
   logic resetn;
   int   checks = 0;
   int   errors = 0;
   int   pulses;

   debounce_arbiter_if #(.N_BTN(NB), .IDX_W(IW)) bus_if ();

   debounce_arbiter #(.N_BTN(NB), .CNT_W(CNT_W_SIM), .IDX_W(IW)) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // expects the press for button id on relative edge 17 and nothing before it
   task automatic expect_press(input string tag, input int id);
      for (int e = 1; e <= 17; e++) begin
         tick();
         chk({tag, "_valid"}, 32'(bus_if.press_valid), 32'(e == 17));
         chk({tag, "_busy"}, 32'(bus_if.busy), 32'(e <= 16));
         if (e == 1) chk({tag, "_grant"}, 32'(bus_if.grant_id), 32'(id));
         if (e == 17) chk({tag, "_id"}, 32'(bus_if.press_id), 32'(id));
      end
   endtask

   initial begin
      resetn        = 1'b0;
      bus_if.btn_in = '0;
      tick();
      tick();
      chk("rst_valid", 32'(bus_if.press_valid), 32'd0);
      chk("rst_id",    32'(bus_if.press_id),    32'd0);
      chk("rst_busy",  32'(bus_if.busy),        32'd0);
      chk("rst_grant", 32'(bus_if.grant_id),    32'd0);
`ifdef DEB_ABORT_CNT_EN
      chk("rst_abort", 32'(bus_if.abort_cnt),   32'd0);
`endif
      resetn = 1'b1;
      tick();

      // button 1 held: one pulse at edge 17, none during a long hold
      bus_if.btn_in = 4'b0010;
      expect_press("b1", 1);
      pulses = 0;
      for (int i = 0; i < 100; i++) begin
         tick();
         if (bus_if.press_valid) pulses++;
         chk("b1_hold_busy", 32'(bus_if.busy), 32'd0);
      end
      chk("b1_hold_pulses", 32'(pulses), 32'd0);
      bus_if.btn_in = 4'b0000;
      tick();

      // button 2 bounces after 6 edges, then a clean press
      bus_if.btn_in = 4'b0100;
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("b2_bounce_busy", 32'(bus_if.busy), 32'd1);
      end
      bus_if.btn_in = 4'b0000;
      tick();
      chk("b2_abort_busy",  32'(bus_if.busy),        32'd0);
      chk("b2_abort_valid", 32'(bus_if.press_valid), 32'd0);
      bus_if.btn_in = 4'b0100;
      expect_press("b2", 2);
      bus_if.btn_in = 4'b0000;
      tick();

      // buttons 0 and 2 together: rr_ptr=3 so 0 first at 17, then 2 at 34
      bus_if.btn_in = 4'b0101;
      for (int e = 1; e <= 40; e++) begin
         tick();
         chk("b02_valid", 32'(bus_if.press_valid), 32'(e == 17 || e == 34));
         if (e == 17) chk("b02_id0", 32'(bus_if.press_id), 32'd0);
         if (e == 34) chk("b02_id2", 32'(bus_if.press_id), 32'd2);
      end
      bus_if.btn_in = 4'b0000;
      tick();

      // button 3 pressed, released, re-pressed: two separate pulses
      bus_if.btn_in = 4'b1000;
      expect_press("b3a", 3);
      bus_if.btn_in = 4'b0000;
      tick();
      bus_if.btn_in = 4'b1000;
      expect_press("b3b", 3);
      bus_if.btn_in = 4'b0000;
      tick();

      // reset during COUNT at cnt=8 aborts silently, count restarts afterwards
      bus_if.btn_in = 4'b0010;
      for (int i = 0; i < 9; i++) tick();
      chk("mid_busy", 32'(bus_if.busy), 32'd1);
      resetn = 1'b0;
      tick();
      chk("mrst_valid", 32'(bus_if.press_valid), 32'd0);
      chk("mrst_id",    32'(bus_if.press_id),    32'd0);
      chk("mrst_busy",  32'(bus_if.busy),        32'd0);
      chk("mrst_grant", 32'(bus_if.grant_id),    32'd0);
      resetn = 1'b1;
      expect_press("b1r", 1);
      bus_if.btn_in = 4'b0000;
      tick();

`ifdef DEB_ABORT_CNT_EN
      for (int a = 0; a < 300; a++) begin
         bus_if.btn_in = 4'b0010;
         tick();
         tick();
         bus_if.btn_in = 4'b0000;
         tick();
         if (a == 2)   chk("abort_3",   32'(bus_if.abort_cnt), 32'd3);
         if (a == 254) chk("abort_255", 32'(bus_if.abort_cnt), 32'd255);
      end
      chk("abort_sat", 32'(bus_if.abort_cnt), 32'd255);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
